// File: rtl/seq_multiplier_n_if.sv
// Handshake and operand/result bundle for seq_multiplier_n.
// The control side uses master; the multiplier uses slave.
interface seq_multiplier_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier_n.sv
// Unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// done is a one-cycle pulse meant to drive the enable of the downstream result register.
module seq_multiplier_n #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  seq_multiplier_n_if.slave bus
);

  // One extra bit so the iteration count never wraps, even for WIDTH=1.
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // mcand_q holds a << count, so this adds a << count when the current b bit is set.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LastCount) begin
          product_d = acc_d;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;

endmodule
